// File: rtl/vector_cache_pkg.sv
// Shared direction encoding and arbiter helpers for the XY router mesh.
// Used by xy_router_node and xy_router_fifo.
package vector_cache_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_WEST  = 2'd0;
  localparam dir_t DIR_EAST  = 2'd1;
  localparam dir_t DIR_SOUTH = 2'd2;
  localparam dir_t DIR_NORTH = 2'd3;

  typedef enum logic [1:0] {
    ARB_W = 2'd0,
    ARB_S = 2'd1,
    ARB_N = 2'd2
  } arb_sel_e;

  function automatic arb_sel_e arb_next(arb_sel_e s);
    case (s)
      ARB_W:   return ARB_S;
      ARB_S:   return ARB_N;
      default: return ARB_W;
    endcase
  endfunction

  function automatic dir_t arb2dir(arb_sel_e s);
    case (s)
      ARB_S:   return DIR_SOUTH;
      ARB_N:   return DIR_NORTH;
      default: return DIR_WEST;
    endcase
  endfunction

endpackage

// File: rtl/xy_router_fifo.sv
// Small synchronous FIFO holding one router output queue.
// Head is masked to zero while empty.
module xy_router_fifo
  import vector_cache_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  // Pointer advance on accepted push/pop.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_d = rd_q + {{AW{1'b0}}, 1'b1};
  end

  // Pointer registers, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage write; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/xy_router_node.sv
// XY mesh router node: straight-through, or merge/demux on a diagonal.
// Optional macro XY_ROUTER_DROP_CNT_EN adds per-channel drop counters.
module xy_router_node
  import vector_cache_pkg::*;
#(
  parameter int BLOCK_ID   = 0,
  parameter int ROW_ID     = 0,
  parameter int CH_NUM     = 8,
  parameter int PLD_W      = 128,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CH_NUM-1:0]             west_in_vld,
  output logic [CH_NUM-1:0]             west_in_rdy,
  input  logic [CH_NUM-1:0][PLD_W-1:0]  west_in_pld,
  input  logic [CH_NUM-1:0][1:0]        west_in_dir,
  input  logic [CH_NUM-1:0]             east_in_vld,
  output logic [CH_NUM-1:0]             east_in_rdy,
  input  logic [CH_NUM-1:0][PLD_W-1:0]  east_in_pld,
  input  logic [CH_NUM-1:0][1:0]        east_in_dir,
  input  logic [CH_NUM-1:0]             south_in_vld,
  output logic [CH_NUM-1:0]             south_in_rdy,
  input  logic [CH_NUM-1:0][PLD_W-1:0]  south_in_pld,
  input  logic [CH_NUM-1:0][1:0]        south_in_dir,
  input  logic [CH_NUM-1:0]             north_in_vld,
  output logic [CH_NUM-1:0]             north_in_rdy,
  input  logic [CH_NUM-1:0][PLD_W-1:0]  north_in_pld,
  input  logic [CH_NUM-1:0][1:0]        north_in_dir,
  output logic [CH_NUM-1:0]             west_out_vld,
  input  logic [CH_NUM-1:0]             west_out_rdy,
  output logic [CH_NUM-1:0][PLD_W-1:0]  west_out_pld,
  output logic [CH_NUM-1:0][1:0]        west_out_dir,
  output logic [CH_NUM-1:0]             east_out_vld,
  input  logic [CH_NUM-1:0]             east_out_rdy,
  output logic [CH_NUM-1:0][PLD_W-1:0]  east_out_pld,
  output logic [CH_NUM-1:0][1:0]        east_out_dir,
  output logic [CH_NUM-1:0]             south_out_vld,
  input  logic [CH_NUM-1:0]             south_out_rdy,
  output logic [CH_NUM-1:0][PLD_W-1:0]  south_out_pld,
  output logic [CH_NUM-1:0][1:0]        south_out_dir,
  output logic [CH_NUM-1:0]             north_out_vld,
  input  logic [CH_NUM-1:0]             north_out_rdy,
  output logic [CH_NUM-1:0][PLD_W-1:0]  north_out_pld,
  output logic [CH_NUM-1:0][1:0]        north_out_dir
`ifdef XY_ROUTER_DROP_CNT_EN
  ,
  output logic [CH_NUM-1:0][15:0]       drop_cnt
`endif
);

  localparam int  W    = PLD_W + 2;
  localparam bit  DIAG = (BLOCK_ID == ROW_ID);

  logic live_q;

  // Holds all in_rdy low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live_q <= 1'b0;
    else        live_q <= 1'b1;
  end

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic [3:0]        iv, ir, ordy;
    logic [3:0][W-1:0] idat;
    logic [3:0]        push, pop, full, empty;
    logic [3:0][W-1:0] wdata, rdata;

    assign iv = {north_in_vld[c], south_in_vld[c],
                 east_in_vld[c], west_in_vld[c]};
    assign ordy = {north_out_rdy[c], south_out_rdy[c],
                   east_out_rdy[c], west_out_rdy[c]};

    assign idat[DIR_WEST]  = {west_in_dir[c], west_in_pld[c]};
    assign idat[DIR_EAST]  = {east_in_dir[c], east_in_pld[c]};
    assign idat[DIR_SOUTH] = {south_in_dir[c], south_in_pld[c]};
    assign idat[DIR_NORTH] = {north_in_dir[c], north_in_pld[c]};

    assign west_in_rdy[c]  = ir[DIR_WEST];
    assign east_in_rdy[c]  = ir[DIR_EAST];
    assign south_in_rdy[c] = ir[DIR_SOUTH];
    assign north_in_rdy[c] = ir[DIR_NORTH];

    for (genvar o = 0; o < 4; o++) begin : g_q
      assign pop[o] = ordy[o] & ~empty[o];
      xy_router_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push[o]),
        .wdata_i (wdata[o]),
        .pop_i   (pop[o]),
        .rdata_o (rdata[o]),
        .full_o  (full[o]),
        .empty_o (empty[o])
      );
    end

    assign west_out_vld[c]  = ~empty[DIR_WEST];
    assign east_out_vld[c]  = ~empty[DIR_EAST];
    assign south_out_vld[c] = ~empty[DIR_SOUTH];
    assign north_out_vld[c] = ~empty[DIR_NORTH];

    assign {west_out_dir[c], west_out_pld[c]}   = rdata[DIR_WEST];
    assign {east_out_dir[c], east_out_pld[c]}   = rdata[DIR_EAST];
    assign {south_out_dir[c], south_out_pld[c]} = rdata[DIR_SOUTH];
    assign {north_out_dir[c], north_out_pld[c]} = rdata[DIR_NORTH];

    if (DIAG) begin : g_diag
      arb_sel_e   ptr_q, ptr_d, gsel, c1, c2;
      logic       gnt_vld, ok_e, drop;
      logic [2:0] req;
      dir_t       tgt;

      assign req = {iv[DIR_NORTH], iv[DIR_SOUTH], iv[DIR_WEST]};

      // Round-robin pick among W/S/N starting at the pointer.
      always_comb begin
        c1      = arb_next(ptr_q);
        c2      = arb_next(c1);
        gnt_vld = 1'b1;
        gsel    = ptr_q;
        if (req[ptr_q])   gsel = ptr_q;
        else if (req[c1]) gsel = c1;
        else if (req[c2]) gsel = c2;
        else              gnt_vld = 1'b0;
      end

      // Merge into E, demux E input by its dir field.
      always_comb begin
        push  = '0;
        wdata = '0;
        ir    = '0;
        ok_e  = live_q & ~full[DIR_EAST];
        ir[arb2dir(gsel)] = gnt_vld & ok_e;
        push[DIR_EAST]    = gnt_vld & iv[arb2dir(gsel)] & ok_e;
        wdata[DIR_EAST]   = idat[arb2dir(gsel)];
        tgt  = east_in_dir[c];
        drop = (tgt == DIR_EAST);
        ir[DIR_EAST] = live_q & (drop | ~full[tgt]);
        if (!drop) begin
          push[tgt]  = iv[DIR_EAST] & ir[DIR_EAST];
          wdata[tgt] = idat[DIR_EAST];
        end
        ptr_d = push[DIR_EAST] ? arb_next(gsel) : ptr_q;
      end

      // Arbiter pointer, restarting at W.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= ARB_W;
        else        ptr_q <= ptr_d;
      end

`ifdef XY_ROUTER_DROP_CNT_EN
      logic [15:0] cnt_q, cnt_d;

      // Saturating count of accepted illegal-dir beats.
      always_comb begin
        cnt_d = cnt_q;
        if (iv[DIR_EAST] && ir[DIR_EAST] && drop && cnt_q != 16'hFFFF)
          cnt_d = cnt_q + 16'd1;
      end

      // Drop counter register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end

      assign drop_cnt[c] = cnt_q;
`endif
    end else begin : g_straight
      // Each output is fed only by the opposite input.
      always_comb begin
        push  = '0;
        wdata = '0;
        ir    = '0;
        ir[DIR_WEST]     = live_q & ~full[DIR_EAST];
        push[DIR_EAST]   = iv[DIR_WEST] & ir[DIR_WEST];
        wdata[DIR_EAST]  = idat[DIR_WEST];
        ir[DIR_EAST]     = live_q & ~full[DIR_WEST];
        push[DIR_WEST]   = iv[DIR_EAST] & ir[DIR_EAST];
        wdata[DIR_WEST]  = idat[DIR_EAST];
        ir[DIR_NORTH]    = live_q & ~full[DIR_SOUTH];
        push[DIR_SOUTH]  = iv[DIR_NORTH] & ir[DIR_NORTH];
        wdata[DIR_SOUTH] = idat[DIR_NORTH];
        ir[DIR_SOUTH]    = live_q & ~full[DIR_NORTH];
        push[DIR_NORTH]  = iv[DIR_SOUTH] & ir[DIR_SOUTH];
        wdata[DIR_NORTH] = idat[DIR_SOUTH];
      end

`ifdef XY_ROUTER_DROP_CNT_EN
      assign drop_cnt[c] = '0;
`endif
    end
  end

endmodule

// File: tb/tb_xy_router_node.sv
// Directed bench for xy_router_node: straight and diagonal instances.
// Drop-counter checks are active when XY_ROUTER_DROP_CNT_EN is defined.
module tb_xy_router_node;

  localparam int CH = 4;
  localparam int PW = 8;

  logic clk;
  logic rst_n;

  // Direction index: 0 W, 1 E, 2 S, 3 N
  logic [3:0][CH-1:0]         s_iv, s_ir, s_ov, s_ordy;
  logic [3:0][CH-1:0][PW-1:0] s_ip, s_op;
  logic [3:0][CH-1:0][1:0]    s_id, s_od;
  logic [3:0][CH-1:0]         d_iv, d_ir, d_ov, d_ordy;
  logic [3:0][CH-1:0][PW-1:0] d_ip, d_op;
  logic [3:0][CH-1:0][1:0]    d_id, d_od;
`ifdef XY_ROUTER_DROP_CNT_EN
  logic [CH-1:0][15:0] s_dc, d_dc;
`endif

  int n_cmp;
  int n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  xy_router_node #(
    .BLOCK_ID(1), .ROW_ID(0), .CH_NUM(CH),
    .PLD_W(PW), .FIFO_DEPTH(2)
  ) u_st (
    .clk(clk), .rst_n(rst_n),
    .west_in_vld(s_iv[0]),  .west_in_rdy(s_ir[0]),
    .west_in_pld(s_ip[0]),  .west_in_dir(s_id[0]),
    .east_in_vld(s_iv[1]),  .east_in_rdy(s_ir[1]),
    .east_in_pld(s_ip[1]),  .east_in_dir(s_id[1]),
    .south_in_vld(s_iv[2]), .south_in_rdy(s_ir[2]),
    .south_in_pld(s_ip[2]), .south_in_dir(s_id[2]),
    .north_in_vld(s_iv[3]), .north_in_rdy(s_ir[3]),
    .north_in_pld(s_ip[3]), .north_in_dir(s_id[3]),
    .west_out_vld(s_ov[0]),  .west_out_rdy(s_ordy[0]),
    .west_out_pld(s_op[0]),  .west_out_dir(s_od[0]),
    .east_out_vld(s_ov[1]),  .east_out_rdy(s_ordy[1]),
    .east_out_pld(s_op[1]),  .east_out_dir(s_od[1]),
    .south_out_vld(s_ov[2]), .south_out_rdy(s_ordy[2]),
    .south_out_pld(s_op[2]), .south_out_dir(s_od[2]),
    .north_out_vld(s_ov[3]), .north_out_rdy(s_ordy[3]),
    .north_out_pld(s_op[3]), .north_out_dir(s_od[3])
`ifdef XY_ROUTER_DROP_CNT_EN
    , .drop_cnt(s_dc)
`endif
  );

  xy_router_node #(
    .BLOCK_ID(0), .ROW_ID(0), .CH_NUM(CH),
    .PLD_W(PW), .FIFO_DEPTH(2)
  ) u_dg (
    .clk(clk), .rst_n(rst_n),
    .west_in_vld(d_iv[0]),  .west_in_rdy(d_ir[0]),
    .west_in_pld(d_ip[0]),  .west_in_dir(d_id[0]),
    .east_in_vld(d_iv[1]),  .east_in_rdy(d_ir[1]),
    .east_in_pld(d_ip[1]),  .east_in_dir(d_id[1]),
    .south_in_vld(d_iv[2]), .south_in_rdy(d_ir[2]),
    .south_in_pld(d_ip[2]), .south_in_dir(d_id[2]),
    .north_in_vld(d_iv[3]), .north_in_rdy(d_ir[3]),
    .north_in_pld(d_ip[3]), .north_in_dir(d_id[3]),
    .west_out_vld(d_ov[0]),  .west_out_rdy(d_ordy[0]),
    .west_out_pld(d_op[0]),  .west_out_dir(d_od[0]),
    .east_out_vld(d_ov[1]),  .east_out_rdy(d_ordy[1]),
    .east_out_pld(d_op[1]),  .east_out_dir(d_od[1]),
    .south_out_vld(d_ov[2]), .south_out_rdy(d_ordy[2]),
    .south_out_pld(d_op[2]), .south_out_dir(d_od[2]),
    .north_out_vld(d_ov[3]), .north_out_rdy(d_ordy[3]),
    .north_out_pld(d_op[3]), .north_out_dir(d_od[3])
`ifdef XY_ROUTER_DROP_CNT_EN
    , .drop_cnt(d_dc)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] arb_exp [6];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    arb_exp = '{8'h01, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03};
    rst_n  = 1'b0;
    s_iv   = '1; s_ip = '0; s_id = '0; s_ordy = '1;
    d_iv   = '1; d_ip = '0; d_id = '0; d_ordy = '1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ov", 32'(s_ov), 0);
    chk("rst_s_ir", 32'(s_ir), 0);
    chk("rst_d_ov", 32'(d_ov), 0);
    chk("rst_d_ir", 32'(d_ir), 0);
    chk("rst_s_op", 32'(s_op[1][3]), 0);
    s_iv = '0;
    d_iv = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ir_low", 32'(s_ir), 0);
    step;
    chk("rel_s_ir", 32'(s_ir), 32'h0000_FFFF);
    chk("rel_d_ir", 32'(d_ir), 32'h0000_00F0);

    // straight W ch3 -> E ch3
    s_iv[0][3] = 1'b1;
    s_ip[0][3] = 8'hA5;
    s_id[0][3] = 2'd1;
    #1;
    chk("st_rdy", 32'(s_ir[0][3]), 1);
    step;
    s_iv[0][3] = 1'b0;
    chk("st_ov", 32'(s_ov), 32'h0000_0080);
    chk("st_pld", 32'(s_op[1][3]), 32'hA5);
    chk("st_dir", 32'(s_od[1][3]), 1);
    step;
    chk("st_drain", 32'(s_ov), 0);

    // backpressure on straight E ch0
    s_ordy[1][0] = 1'b0;
    s_iv[0][0] = 1'b1;
    s_ip[0][0] = 8'h10;
    #1;
    chk("bp_rdy0", 32'(s_ir[0][0]), 1);
    step;
    s_ip[0][0] = 8'h11;
    #1;
    chk("bp_rdy1", 32'(s_ir[0][0]), 1);
    step;
    s_ip[0][0] = 8'h12;
    #1;
    chk("bp_full", 32'(s_ir[0][0]), 0);
    chk("bp_ch1_free", 32'(s_ir[0][1]), 1);
    step;
    chk("bp_hold", 32'(s_ir[0][0]), 0);
    chk("bp_head0", 32'(s_op[1][0]), 32'h10);
    s_ordy[1][0] = 1'b1;
    #1;
    chk("bp_nobypass", 32'(s_ir[0][0]), 0);
    step;
    s_ordy[1][0] = 1'b0;
    #1;
    chk("bp_one_more", 32'(s_ir[0][0]), 1);
    step;
    chk("bp_full2", 32'(s_ir[0][0]), 0);
    s_iv[0][0] = 1'b0;
    s_ordy[1][0] = 1'b1;
    chk("bp_head1", 32'(s_op[1][0]), 32'h11);
    step;
    chk("bp_head2", 32'(s_op[1][0]), 32'h12);
    step;
    chk("bp_empty", 32'(s_ov[1][0]), 0);

    // fairness on diagonal ch0
    d_iv[0][0] = 1'b1; d_ip[0][0] = 8'h01;
    d_iv[2][0] = 1'b1; d_ip[2][0] = 8'h02;
    d_iv[3][0] = 1'b1; d_ip[3][0] = 8'h03;
    #1;
    chk("arb_w_rdy", 32'(d_ir[0][0]), 1);
    chk("arb_s_rdy", 32'(d_ir[2][0]), 0);
    chk("arb_n_rdy", 32'(d_ir[3][0]), 0);
    for (int i = 0; i < 6; i++) begin
      step;
      chk("arb_vld", 32'(d_ov[1][0]), 1);
      chk("arb_order", 32'(d_op[1][0]), 32'(arb_exp[i]));
    end
    d_iv[0][0] = 1'b0;
    d_iv[2][0] = 1'b0;
    d_iv[3][0] = 1'b0;
    step;
    chk("arb_drain", 32'(d_ov), 0);

    // demux on diagonal E ch2
    d_iv[1][2] = 1'b1;
    d_id[1][2] = 2'd0;
    d_ip[1][2] = 8'h40;
    step;
    chk("dmx_w_ov", 32'(d_ov), 32'h0000_0004);
    chk("dmx_w_pld", 32'(d_op[0][2]), 32'h40);
    d_id[1][2] = 2'd2;
    d_ip[1][2] = 8'h42;
    step;
    chk("dmx_s_ov", 32'(d_ov), 32'h0000_0400);
    chk("dmx_s_pld", 32'(d_op[2][2]), 32'h42);
    d_id[1][2] = 2'd3;
    d_ip[1][2] = 8'h43;
    step;
    chk("dmx_n_ov", 32'(d_ov), 32'h0000_4000);
    chk("dmx_n_pld", 32'(d_op[3][2]), 32'h43);
    d_id[1][2] = 2'd1;
    d_ip[1][2] = 8'h44;
    #1;
    chk("dmx_drop_rdy", 32'(d_ir[1][2]), 1);
    step;
    d_iv[1][2] = 1'b0;
    chk("dmx_drop_ov", 32'(d_ov), 0);
`ifdef XY_ROUTER_DROP_CNT_EN
    chk("dmx_cnt2", 32'(d_dc[2]), 1);
    chk("dmx_cnt0", 32'(d_dc[0]), 0);
`endif

    // reset mid-stream
    d_ordy[1][0] = 1'b0;
    d_iv[0][0] = 1'b1;
    d_ip[0][0] = 8'h55;
    s_ordy[1][1] = 1'b0;
    s_iv[0][1] = 1'b1;
    s_ip[0][1] = 8'h66;
    step;
    s_iv[0][1] = 1'b0;
    chk("mid_d_vld", 32'(d_ov[1][0]), 1);
    chk("mid_s_vld", 32'(s_ov[1][1]), 1);
    d_iv[2][0] = 1'b1;
    d_iv[3][0] = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_d_ov", 32'(d_ov), 0);
    chk("mid_rst_s_ov", 32'(s_ov), 0);
    chk("mid_rst_d_ir", 32'(d_ir), 0);
    @(negedge clk);
    rst_n = 1'b1;
    d_ordy = '1;
    s_ordy = '1;
    step;
    chk("post_d_ov", 32'(d_ov), 0);
    chk("post_s_ov", 32'(s_ov), 0);
    chk("post_w_rdy", 32'(d_ir[0][0]), 1);
    chk("post_s_rdy", 32'(d_ir[2][0]), 0);
    step;
    chk("post_first", 32'(d_op[1][0]), 32'h55);
    chk("post_vld", 32'(d_ov[1][0]), 1);
    d_iv = '0;
    step;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
